// File: rtl/agc_pkg.sv
// Shared definitions for the AGC scale servo: FSM states, datapath widths
// and the scale clamp used by the update step.
package agc_pkg;

   localparam int SCALE_UNITY = 4096;   // scale value meaning gain 1.0
   localparam int RMS_W       = 12;     // Q2.10 RMS width
   localparam int SCALE_W     = 17;     // gain scale width
   localparam int OFFSET_W    = 8;      // signed offset width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TICK,
      ST_MEASURE,
      ST_SETTLE,
      ST_SQRT,
      ST_UPDATE,
      ST_APPLY
   } agc_state_e;

   // Clamp a signed, two-bit-wider scale candidate into [min_val, 2^SCALE_W-1].
   function automatic logic [SCALE_W-1:0] clamp_scale(input logic signed [SCALE_W+1:0] val,
                                                      input logic [SCALE_W-1:0] min_val);
      if (val < $signed({2'b00, min_val}))
         return min_val;
      if (val > $signed({2'b00, {SCALE_W{1'b1}}}))
         return {SCALE_W{1'b1}};
      return val[SCALE_W-1:0];
   endfunction

endpackage

// File: rtl/agc_scale_servo_if.sv
// Bus between the AGC servo and the per-channel core: accumulator control
// and readback, plus the scale/offset load and apply strobes.
interface agc_scale_servo_if #(
   parameter int SQ_BITS = 24,
   parameter int PR_BITS = 21
);
   import agc_pkg::*;

   logic                       agc_tick;
   logic                       agc_ce;
   logic [SQ_BITS-1:0]         sq_accum;
   logic [PR_BITS-1:0]         gt_accum;
   logic [PR_BITS-1:0]         lt_accum;
   logic [SCALE_W-1:0]         scale;
   logic                       scale_ce;
   logic signed [OFFSET_W-1:0] offset;
   logic                       offset_ce;
   logic                       apply;

   modport master (
      output agc_tick, agc_ce, scale, scale_ce, offset, offset_ce, apply,
      input  sq_accum, gt_accum, lt_accum
   );

   modport slave (
      input  agc_tick, agc_ce, scale, scale_ce, offset, offset_ce, apply,
      output sq_accum, gt_accum, lt_accum
   );

endinterface

// File: rtl/agc_isqrt.sv
// Digit-by-digit integer square root: floor(sqrt(in_i)), one root bit per
// clock, RMS_W clocks after start_i. valid_o stays high until the next start.
module agc_isqrt
   import agc_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [2*RMS_W-1:0] in_i,
   output logic [RMS_W-1:0]   out_o,
   output logic               valid_o
);

   localparam int IN_W  = 2 * RMS_W;
   localparam int REM_W = RMS_W + 3;    // holds 4*rem+3 with rem <= 2*root
   localparam int CNT_W = $clog2(RMS_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RMS_W - 1);

   logic [IN_W-1:0]  rad_reg;
   logic [REM_W-1:0] rem_reg;
   logic [RMS_W-1:0] root_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;
   logic             valid_reg;

   logic [REM_W-1:0] rem_shift;
   logic [REM_W-1:0] trial;
   logic             fits;

   // Bring down the next two radicand bits and test root*4+1 against them.
   always_comb begin
      rem_shift = {rem_reg[REM_W-3:0], rad_reg[IN_W-1 -: 2]};
      trial     = REM_W'({root_reg, 2'b01});
      fits      = (rem_shift >= trial);
   end

   // Iteration registers: load on start, then resolve one root bit per clock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rad_reg   <= '0;
         rem_reg   <= '0;
         root_reg  <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else if (start_i) begin
         rad_reg   <= in_i;
         rem_reg   <= '0;
         root_reg  <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b1;
         valid_reg <= 1'b0;
      end else if (busy_reg) begin
         rad_reg  <= {rad_reg[IN_W-3:0], 2'b00};
         rem_reg  <= fits ? (rem_shift - trial) : rem_shift;
         root_reg <= {root_reg[RMS_W-2:0], fits};
         cnt_reg  <= cnt_reg + CNT_W'(1);
         if (cnt_reg == LAST) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
         end
      end
   end

   assign out_o   = root_reg;
   assign valid_o = valid_reg;

endmodule

// File: rtl/agc_scale_servo.sv
// AGC scale servo: runs measurement cycles on the accumulator core, takes
// the square root of the accumulated power and steps the gain scale toward
// the target RMS. Define AGC_OFFSET_SERVO_EN to also servo the DC offset
// from the probit accumulators; otherwise offset stays at zero.
module agc_scale_servo
   import agc_pkg::*;
#(
   parameter int NCLK_LOG2  = 17,
   parameter int ACC_LAT    = 4,
   parameter int SQ_BITS    = 24,
   parameter int PR_BITS    = 21,
   parameter int SCALE_INIT = SCALE_UNITY,
   parameter int SCALE_MIN  = 1024
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               run_i,
   input  logic [RMS_W-1:0]   target_i,
   input  logic [3:0]         gain_shift_i,
   agc_scale_servo_if.master  bus,
   output logic [RMS_W-1:0]   rms_o,
   output logic               done_o,
   output logic               busy_o
);

   localparam int CNT_W    = NCLK_LOG2 + 1;
   localparam int SQ_EXT_W = 2 * RMS_W;
   localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'((1 << NCLK_LOG2) - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ACC_LAT);
   localparam logic [CNT_W-1:0] SQRT_LAST   = CNT_W'(RMS_W - 1);

   agc_state_e state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             sqrt_start;
   logic             sqrt_valid;
   logic [RMS_W-1:0] sqrt_out;

   logic [SQ_BITS-1:0]  sq_in;
   logic [SQ_EXT_W-1:0] sq_ext;

   logic [RMS_W-1:0]           rms_reg;
   logic [SCALE_W-1:0]         scale_reg;
   logic [SCALE_W-1:0]         scale_new;
   logic signed [RMS_W:0]      err;
   logic signed [RMS_W:0]      delta;
   logic signed [SCALE_W+1:0]  scale_wide;
   logic                       scale_ce_reg;
   logic                       apply_reg;
   logic                       update_en;

   assign sq_in  = bus.sq_accum;
   assign sq_ext = SQ_EXT_W'(sq_in);

   // State and shared cycle counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Sequencing; the final SETTLE clock is the capture clock that starts the root.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sqrt_start = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (run_i) state_next = ST_TICK;
         end
         ST_TICK: begin
            cnt_next   = '0;
            state_next = run_i ? ST_MEASURE : ST_IDLE;
         end
         ST_MEASURE: begin
            if (!run_i) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == MEAS_LAST) begin
               state_next = ST_SETTLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (!run_i) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == SETTLE_LAST) begin
               state_next = ST_SQRT;
               cnt_next   = '0;
               sqrt_start = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_SQRT: begin
            if (cnt_reg == SQRT_LAST) begin
               state_next = ST_UPDATE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_UPDATE: state_next = ST_APPLY;
         ST_APPLY:  state_next = run_i ? ST_TICK : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   agc_isqrt u_isqrt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (sqrt_start),
      .in_i    (sq_ext),
      .out_o   (sqrt_out),
      .valid_o (sqrt_valid)
   );

   // Error, shifted correction and clamped candidate scale.
   always_comb begin
      err        = $signed({1'b0, sqrt_out}) - $signed({1'b0, target_i});
      delta      = err >>> gain_shift_i;
      scale_wide = $signed({2'b00, scale_reg})
                 - $signed({{(SCALE_W + 1 - RMS_W){delta[RMS_W]}}, delta});
      scale_new  = clamp_scale(scale_wide, SCALE_W'(SCALE_MIN));
   end

   assign update_en = (state_reg == ST_UPDATE) && sqrt_valid;

   // Result registers; scale_ce coincides with the new scale, apply follows a clock later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rms_reg      <= '0;
         scale_reg    <= SCALE_W'(SCALE_INIT);
         scale_ce_reg <= 1'b0;
         apply_reg    <= 1'b0;
      end else begin
         scale_ce_reg <= update_en;
         apply_reg    <= (state_reg == ST_APPLY);
         if (update_en) begin
            rms_reg   <= sqrt_out;
            scale_reg <= scale_new;
         end
      end
   end

`ifdef AGC_OFFSET_SERVO_EN
   logic [PR_BITS-1:0]         gt_cap_reg;
   logic [PR_BITS-1:0]         lt_cap_reg;
   logic signed [OFFSET_W-1:0] offset_reg;
   logic                       offset_ce_reg;

   // Probit counts are captured on the same clock as the square accumulator.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gt_cap_reg <= '0;
         lt_cap_reg <= '0;
      end else if (sqrt_start) begin
         gt_cap_reg <= bus.gt_accum;
         lt_cap_reg <= bus.lt_accum;
      end
   end

   // Offset steps one LSB against the probit imbalance, saturating at the rails.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         offset_reg    <= '0;
         offset_ce_reg <= 1'b0;
      end else begin
         offset_ce_reg <= update_en;
         if (update_en) begin
            if (gt_cap_reg > lt_cap_reg && offset_reg != 8'sh80)
               offset_reg <= offset_reg - 8'sd1;
            else if (lt_cap_reg > gt_cap_reg && offset_reg != 8'sh7F)
               offset_reg <= offset_reg + 8'sd1;
         end
      end
   end

   assign bus.offset    = offset_reg;
   assign bus.offset_ce = offset_ce_reg;
`else
   logic [PR_BITS-1:0] unused_probit;
   assign unused_probit = bus.gt_accum ^ bus.lt_accum;
   assign bus.offset    = '0;
   assign bus.offset_ce = 1'b0;
`endif

   assign bus.agc_tick = (state_reg == ST_TICK);
   assign bus.agc_ce   = (state_reg == ST_MEASURE);
   assign bus.scale    = scale_reg;
   assign bus.scale_ce = scale_ce_reg;
   assign bus.apply    = apply_reg;
   assign rms_o        = rms_reg;
   assign done_o       = apply_reg;
   assign busy_o       = (state_reg != ST_IDLE);

endmodule
